// File: rtl/io_in_dec.sv
// io_in_dec: memory-mapped input decoder for board switches and push-buttons.
// Raw inputs are synchronized, debounced on a prescaler tick, and button
// rising edges are latched into a write-1-to-clear event register.
// Register map (addr[15:0], bus data byte-swapped both ways):
//   f300 SW (RO), f304 BTN (RO), f308 EVT (RW1C), f30c MASK (RW, optional)
// Optional feature macro: IO_IN_IRQ_EN adds the MASK register and irq output.
module io_in_dec #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000,
  parameter int          NUM_SW     = 16,
  parameter int          NUM_BTN    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [31:0]        addr,
  input  logic [31:0]        din,
  input  logic               we,
  output logic [31:0]        dout,
`ifdef IO_IN_IRQ_EN
  output logic               irq,
`endif
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_BTN-1:0] btn
);

  // Switches occupy the low bits of the combined input vector, buttons the top.
  localparam int NIN = NUM_SW + NUM_BTN;

  localparam logic [15:0] ADDR_SW   = 16'hf300;
  localparam logic [15:0] ADDR_BTN  = 16'hf304;
  localparam logic [15:0] ADDR_EVT  = 16'hf308;
  localparam logic [15:0] ADDR_MASK = 16'hf30c;

  // The bus carries words with their byte order reversed; the swap is its own inverse.
  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  logic [NIN-1:0]     raw;
  logic [NIN-1:0]     sync1_q, sync2_q;
  logic [NIN-1:0]     samp_q, samp_d;
  logic [NIN-1:0]     stable_q, stable_d;
  logic [NUM_BTN-1:0] stable_dly_q;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] evt_q, evt_d, evt_clr;
  logic [19:0]        cnt_q, cnt_d;
  logic               tick;
  logic [31:0]        wdata;
  logic               wr_hit;
  logic [31:0]        rd_v;
  logic               unused_bits;

  assign raw    = {btn, sw};
  assign wdata  = bswap(din);
  assign wr_hit = ce && we;

  // Prescaler: free-running 0..DEB_CYCLES-1, tick on the last count.
  assign tick  = (cnt_q == DEB_CYCLES - 20'd1);
  assign cnt_d = tick ? 20'd0 : cnt_q + 20'd1;

  // A sample only reaches the stable level when two consecutive ticks agree,
  // so any pulse shorter than one tick period is filtered out.
  assign samp_d = tick ? sync2_q : samp_q;
  for (genvar gi = 0; gi < NIN; gi++) begin : g_deb
    assign stable_d[gi] = (tick && (samp_q[gi] == sync2_q[gi])) ? sync2_q[gi] : stable_q[gi];
  end

  // Set has priority over clear so a press coinciding with a clear is kept.
  assign rise    = stable_q[NIN-1:NUM_SW] & ~stable_dly_q;
  assign evt_clr = (wr_hit && (addr[15:0] == ADDR_EVT)) ? wdata[NUM_BTN-1:0] : '0;
  assign evt_d   = (evt_q & ~evt_clr) | rise;

  // Synchronizer, prescaler, debounce and event state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      samp_q       <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      evt_q        <= '0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      samp_q       <= samp_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q[NIN-1:NUM_SW];
      evt_q        <= evt_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef IO_IN_IRQ_EN
  logic [NUM_BTN-1:0] mask_q, mask_d;
  logic               irq_q;

  assign mask_d = (wr_hit && (addr[15:0] == ADDR_MASK)) ? wdata[NUM_BTN-1:0] : mask_q;
  assign irq    = irq_q;

  // Interrupt mask register and registered interrupt (lags EVT by one cycle).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |(evt_q & mask_q);
    end
  end
`endif

  // Read mux: zero when deselected or unmapped; reads have no side effects.
  always_comb begin
    rd_v = '0;
    if (ce) begin
      case (addr[15:0])
        ADDR_SW:  rd_v[NUM_SW-1:0]  = stable_q[NUM_SW-1:0];
        ADDR_BTN: rd_v[NUM_BTN-1:0] = stable_q[NIN-1:NUM_SW];
        ADDR_EVT: rd_v[NUM_BTN-1:0] = evt_q;
`ifdef IO_IN_IRQ_EN
        ADDR_MASK: rd_v[NUM_BTN-1:0] = mask_q;
`endif
        default: rd_v = '0;
      endcase
    end
  end

  assign dout = bswap(rd_v);

  // Upper address bits are not decoded and upper write-data bits have no register.
  assign unused_bits = ^{addr[31:16], wdata};

endmodule
